// File: rtl/inst_fetch_buffer.sv
// Fetch buffer: issues word fetches and realigns RVC/32-bit instructions into a DEPTH-entry queue.
// FETCH_RVC_EN enables compressed realignment; without it every word is one 32-bit instruction.
module inst_fetch_buffer #(
   parameter int unsigned     XLEN     = 64,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 64'h1000
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            fetch_req,
   output logic [XLEN-1:0] fetch_addr,
   input  logic            fetch_valid,
   input  logic [31:0]     fetch_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst,
   output logic            inst_comp,
   output logic [XLEN-1:0] inst_pc,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
`ifdef FETCH_RVC_EN
   localparam int unsigned MIN_FREE = 2;
`else
   localparam int unsigned MIN_FREE = 1;
`endif

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
   typedef struct packed {
      logic [31:0]     inst;
      logic [XLEN-1:0] pc;
   } entry_t;

   state_t           state_q, state_d;
   logic             fetch_req_d;
   logic [XLEN-1:0]  fetch_addr_d;
   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d, free;
   logic             inst_valid_d, inst_comp_d;
   logic [31:0]      inst_d;
   logic [XLEN-1:0]  inst_pc_d;
   entry_t           push0, push1, head;
   logic [1:0]       n_push;
   logic             pop, accept;

`ifdef FETCH_RVC_EN
   logic             so_q, so_d;
   logic [15:0]      hbuf_q, hbuf_d;
   logic [XLEN-1:0]  hbuf_pc_q, hbuf_pc_d;
   logic             hbuf_v_q, hbuf_v_d;
   logic             upper;
   logic             unused_redirect_lsb;
   assign unused_redirect_lsb = redirect_pc[0];
`else
   logic [1:0]       unused_redirect_lsb;
   assign unused_redirect_lsb = redirect_pc[1:0];
`endif

   // Next-state: FSM, word realignment, queue update and registered head outputs
   always_comb begin
      state_d      = state_q;
      fetch_req_d  = 1'b0;
      fetch_addr_d = fetch_addr_q_w();
      mem_d        = mem_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      push0        = '0;
      push1        = '0;
      n_push       = 2'd0;
      pop          = inst_valid & inst_ready;
      accept       = (state_q == WAIT) && fetch_valid;
      free         = CNT_W'(DEPTH) - count_q;
`ifdef FETCH_RVC_EN
      so_d         = so_q;
      hbuf_d       = hbuf_q;
      hbuf_pc_d    = hbuf_pc_q;
      hbuf_v_d     = hbuf_v_q;
      upper        = 1'b1;
`endif

      if (accept && !redirect) begin
`ifdef FETCH_RVC_EN
         if (hbuf_v_q) begin
            push0  = '{inst: {fetch_data[15:0], hbuf_q}, pc: hbuf_pc_q};
            n_push = 2'd1;
         end else if (!so_q) begin
            if (fetch_data[1:0] != 2'b11) begin
               push0 = '{inst: {16'h0000, fetch_data[15:0]}, pc: fetch_addr};
            end else begin
               push0 = '{inst: fetch_data, pc: fetch_addr};
               upper = 1'b0;
            end
            n_push = 2'd1;
         end
         hbuf_v_d = 1'b0;
         if (upper) begin
            if (fetch_data[17:16] != 2'b11) begin
               if (n_push == 2'd0) push0 = '{inst: {16'h0000, fetch_data[31:16]}, pc: fetch_addr + XLEN'(2)};
               else                push1 = '{inst: {16'h0000, fetch_data[31:16]}, pc: fetch_addr + XLEN'(2)};
               n_push = n_push + 2'd1;
            end else begin
               hbuf_d    = fetch_data[31:16];
               hbuf_pc_d = fetch_addr + XLEN'(2);
               hbuf_v_d  = 1'b1;
            end
         end
         so_d = 1'b0;
`else
         push0  = '{inst: fetch_data, pc: fetch_addr};
         n_push = 2'd1;
`endif
         fetch_addr_d = fetch_addr + XLEN'(4);
      end

      case (state_q)
         IDLE:    if (!redirect && free >= CNT_W'(MIN_FREE)) begin
                     state_d     = WAIT;
                     fetch_req_d = 1'b1;
                  end
         WAIT:    if (fetch_valid) state_d = IDLE;
                  else if (redirect) state_d = DROP;
         DROP:    if (fetch_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (redirect) begin
         rd_ptr_d     = '0;
         wr_ptr_d     = '0;
         count_d      = '0;
         fetch_addr_d = {redirect_pc[XLEN-1:2], 2'b00};
`ifdef FETCH_RVC_EN
         hbuf_v_d     = 1'b0;
         so_d         = redirect_pc[1];
`endif
      end else begin
         if (n_push != 2'd0) mem_d[wr_ptr_q] = push0;
         if (n_push == 2'd2) mem_d[wr_ptr_q + PTR_W'(1)] = push1;
         wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(n_push) - CNT_W'(pop);
      end

      head         = mem_d[rd_ptr_d];
      inst_valid_d = (count_d != '0);
      inst_d       = inst_valid_d ? head.inst : 32'h0;
      inst_pc_d    = inst_valid_d ? head.pc : '0;
`ifdef FETCH_RVC_EN
      inst_comp_d  = inst_valid_d && (head.inst[1:0] != 2'b11);
`else
      inst_comp_d  = 1'b0;
`endif
   end

   function automatic logic [XLEN-1:0] fetch_addr_q_w();
      return fetch_addr;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         fetch_req  <= 1'b0;
         fetch_addr <= {RESET_PC[XLEN-1:2], 2'b00};
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         inst_valid <= 1'b0;
         inst       <= 32'h0;
         inst_comp  <= 1'b0;
         inst_pc    <= '0;
`ifdef FETCH_RVC_EN
         so_q       <= RESET_PC[1];
         hbuf_q     <= 16'h0;
         hbuf_pc_q  <= '0;
         hbuf_v_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         fetch_req  <= fetch_req_d;
         fetch_addr <= fetch_addr_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         inst_valid <= inst_valid_d;
         inst       <= inst_d;
         inst_comp  <= inst_comp_d;
         inst_pc    <= inst_pc_d;
`ifdef FETCH_RVC_EN
         so_q       <= so_d;
         hbuf_q     <= hbuf_d;
         hbuf_pc_q  <= hbuf_pc_d;
         hbuf_v_q   <= hbuf_v_d;
`endif
      end
   end

   // Queue storage is datapath only; validity comes from count_q
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Randomized bench for inst_fetch_buffer: a PC-walking instruction-stream model over a lazily
// generated memory image predicts queue contents, fetch addresses and fetch_req timing.
module tb_inst_fetch_buffer;
   localparam int unsigned XLEN     = 64;
   localparam int unsigned DEPTH    = 4;
   localparam logic [63:0] RESET_PC = 64'h1000;
`ifdef FETCH_RVC_EN
   localparam int unsigned GATE = 2;
`else
   localparam int unsigned GATE = 1;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic            fetch_req;
   logic [XLEN-1:0] fetch_addr;
   logic            fetch_valid;
   logic [31:0]     fetch_data;
   logic            inst_valid;
   logic            inst_ready;
   logic [31:0]     inst;
   logic            inst_comp;
   logic [XLEN-1:0] inst_pc;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;

   inst_fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_valid (fetch_valid),
      .fetch_data  (fetch_data),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst        (inst),
      .inst_comp   (inst_comp),
      .inst_pc     (inst_pc),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic        comp;
      logic [63:0] pc;
   } exp_t;

   exp_t        q[$];
   logic [31:0] img [logic [63:0]];
   int unsigned n_vec, n_err;

   logic [63:0] walk_pc, next_fa, pend_addr;
   logic        pend, dropped, req_exp, stall;
   int unsigned delay;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] word_at(input logic [63:0] a);
      logic [31:0] w;
      if (!img.exists(a)) begin
         w = $urandom;
         if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
         if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
         img[a] = w;
      end
      return img[a];
   endfunction

   function automatic logic [15:0] half_at(input logic [63:0] pc);
      logic [31:0] w;
      w = word_at({pc[63:2], 2'b00});
      return pc[1] ? w[31:16] : w[15:0];
   endfunction

   // Every instruction that ends within the word at a becomes available
   task automatic word_arrived(input logic [63:0] a);
      exp_t        e;
      logic [15:0] h;
      logic [63:0] len;
      bit          go;
      go = 1'b1;
      while (go) begin
`ifdef FETCH_RVC_EN
         h   = half_at(walk_pc);
         len = (h[1:0] != 2'b11) ? 64'd2 : 64'd4;
`else
         h   = 16'h0;
         len = 64'd4;
`endif
         if (walk_pc + len - a > 64'd4) begin
            go = 1'b0;
         end else begin
`ifdef FETCH_RVC_EN
            if (len == 64'd2) e = '{inst: {16'h0, h}, comp: 1'b1, pc: walk_pc};
            else              e = '{inst: {half_at(walk_pc + 64'd2), h}, comp: 1'b0, pc: walk_pc};
`else
            e = '{inst: word_at(walk_pc), comp: 1'b0, pc: walk_pc};
`endif
            q.push_back(e);
            walk_pc = walk_pc + len;
         end
      end
   endtask

   task automatic model_reset();
      q.delete();
`ifdef FETCH_RVC_EN
      walk_pc = {RESET_PC[63:1], 1'b0};
`else
      walk_pc = {RESET_PC[63:2], 2'b00};
`endif
      next_fa = {RESET_PC[63:2], 2'b00};
      pend    = 1'b0;
      dropped = 1'b0;
      req_exp = 1'b1;
   endtask

   // Check outputs against the model, drive inputs for the next edge, advance the model
   task automatic step(input int cyc);
      logic        do_rd, fv, idle, pop;
      logic [63:0] rpc;
      check("inst_valid", 64'(inst_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         check("inst", 64'(inst), 64'(q[0].inst));
         check("inst_comp", 64'(inst_comp), 64'(q[0].comp));
         check("inst_pc", inst_pc, q[0].pc);
      end else begin
         check("inst_empty", 64'(inst), 64'h0);
         check("inst_pc_empty", inst_pc, 64'h0);
      end
      check("fetch_req", 64'(fetch_req), 64'(req_exp));
      if (fetch_req && !pend) begin
         check("fetch_addr", fetch_addr, next_fa);
         pend      = 1'b1;
         pend_addr = next_fa;
         dropped   = 1'b0;
         delay     = $urandom_range(0, 3);
      end
      idle = !pend;

      fv = pend && (delay == 0);
      if (pend && delay != 0) delay--;
      do_rd = ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 3))
         0:       rpc = 64'h2000 + 64'($urandom_range(0, 63)) * 64'd2;
         1:       rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
         2:       rpc = {32'h0, $urandom};
         default: rpc = 64'h2002 | 64'($urandom_range(0, 1));
      endcase
      if (cyc % 50 == 0) stall = ($urandom_range(0, 2) == 0);
      inst_ready  = stall ? 1'b0 : ($urandom_range(0, 9) < 7);
      redirect    = do_rd;
      redirect_pc = rpc;
      fetch_valid = fv;
      fetch_data  = fv ? word_at(pend_addr) : $urandom;

      req_exp = idle && !do_rd && ((DEPTH - q.size()) >= GATE);
      pop     = inst_valid && inst_ready;
      if (do_rd) begin
         q.delete();
`ifdef FETCH_RVC_EN
         walk_pc = {rpc[63:1], 1'b0};
`else
         walk_pc = {rpc[63:2], 2'b00};
`endif
         next_fa = {rpc[63:2], 2'b00};
         if (pend && !fv) dropped = 1'b1;
         if (fv) pend = 1'b0;
      end else begin
         if (pop && q.size() != 0) void'(q.pop_front());
         if (fv) begin
            pend = 1'b0;
            if (!dropped) begin
               word_arrived(pend_addr);
               next_fa = next_fa + 64'd4;
            end
         end
      end
   endtask

   initial begin
      bit did_rst;
      n_vec       = 0;
      n_err       = 0;
      rst_n       = 1'b0;
      fetch_valid = 1'b0;
      fetch_data  = 32'h0;
      inst_ready  = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 64'h0;
      stall       = 1'b0;
      delay       = 0;
      did_rst     = 1'b0;
      img[64'h1000] = 32'h0013_4501;
      img[64'h1004] = 32'h4501_0000;

      repeat (3) @(negedge clk);
      check("rst_fetch_req", 64'(fetch_req), 64'h0);
      check("rst_fetch_addr", fetch_addr, {RESET_PC[63:2], 2'b00});
      check("rst_inst_valid", 64'(inst_valid), 64'h0);
      check("rst_inst", 64'(inst), 64'h0);
      check("rst_inst_comp", 64'(inst_comp), 64'h0);
      check("rst_inst_pc", inst_pc, 64'h0);
      model_reset();
      rst_n = 1'b1;

      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         if (!did_rst && cyc >= 1500 && ((pend && q.size() >= 2) || cyc >= 3000)) begin
            did_rst     = 1'b1;
            fetch_valid = 1'b0;
            redirect    = 1'b0;
            inst_ready  = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            check("async_rst_inst_valid", 64'(inst_valid), 64'h0);
            check("async_rst_fetch_addr", fetch_addr, {RESET_PC[63:2], 2'b00});
            check("async_rst_fetch_req", 64'(fetch_req), 64'h0);
            check("async_rst_inst_pc", inst_pc, 64'h0);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            model_reset();
         end else begin
            step(cyc);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
Parametrised successor to the single-instruction fetch path. It sits between the fetch port of instcache (or rom) and the decode/stimulator side. It issues word-aligned fetches and realigns 16-bit RVC and 32-bit instructions, including 32-bit instructions that straddle a word boundary. Realigned instructions go into a DEPTH-entry queue with a ready/valid output. It also supports a redirect that flushes the queue and any in-flight fetch.

Parameters:
XLEN, 64, width of fetch_addr, redirect_pc, inst_pc
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 64'h1000, first fetch address after reset; bit 1 selects the starting halfword

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
fetch_req  out  1  one-cycle request pulse
fetch_addr  out  XLEN  word-aligned address; bits [1:0] always 0
fetch_valid  in  1  response beat for the outstanding request
fetch_data  in  32  word at fetch_addr
inst_valid  out  1  queue head valid
inst_ready  in  1  consumer accepts head
inst  out  32  instruction; compressed instructions are zero-extended in [15:0]
inst_comp  out  1  head is RVC (inst[1:0] != 2'b11)
inst_pc  out  XLEN  PC of head instruction
redirect  in  1  flush and restart
redirect_pc  in  XLEN  new PC; bit 0 is ignored

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: fetch_req=0, fetch_addr=RESET_PC & ~3, queue empty, inst_valid=0, inst=0, inst_comp=0, inst_pc=0, halfword buffer invalid, FSM=IDLE, start offset=RESET_PC[1].
- Reset mid-operation: all state returns to the reset values immediately; an in-flight response is not tracked after reset.
- Output when queue empty: inst, inst_comp and inst_pc are driven 0.
- FSM states: IDLE, WAIT, DROP.
  - IDLE -> WAIT: pulse fetch_req when free entries >= 2. Pops in the same cycle are not counted as freeing entries.
  - WAIT -> IDLE: on fetch_valid; the word is processed, then fetch_addr += 4 and the start offset is cleared to 0.
  - WAIT -> DROP: on redirect.
  - DROP -> IDLE: on fetch_valid; the data is discarded and fetch_addr is unchanged.
  - Redirect in IDLE or DROP: stays in the same state.
  - fetch_valid in IDLE: ignored.
- At most one fetch is outstanding at any time.
- Word processing (at most 2 queue pushes per word):
  - If the halfword buffer is valid: push {fetch_data[15:0], hbuf} with pc=hbuf_pc and comp=0, then process the upper half.
  - Else if the start offset is 0:
    - If fetch_data[1:0] != 2'b11: push the low half as RVC, then process the upper half.
    - Otherwise: push the full 32-bit word.
  - Upper half: if [17:16] != 2'b11, push it as RVC with pc=addr+2. Otherwise store it in hbuf with hbuf_pc=addr+2.
- Latency: fetch_valid in cycle N gives inst_valid=1 in cycle N+1. The earliest fetch_req is the first clk edge after rst_n deasserts.
- Queue behaviour:
  - Pop on inst_valid & inst_ready.
  - A simultaneous push and pop is legal.
  - Pointers wrap modulo DEPTH.
  - A push never occurs when full; the free-entries >= 2 gate guarantees this.
- Redirect (priority over push, pop and fetch in the same cycle):
  - Queue cleared and hbuf invalidated.
  - fetch_addr = {redirect_pc[XLEN-1:2], 2'b00}; start offset = redirect_pc[1].
  - The next cycle inst_valid=0.
  - A redirect coinciding with fetch_valid in WAIT drops that word and goes to IDLE.
- Address arithmetic wraps modulo 2^XLEN.

Optional Feature:
FETCH_RVC_EN
- Defined: behaviour exactly as above.
- Undefined:
  - Every word is pushed whole as one 32-bit instruction with comp=0, and inst_comp is tied 0.
  - The hbuf logic is removed and redirect_pc[1] is ignored (start offset is always 0).
  - Free-entries gate becomes >= 1.

Test Plan:
1. Reset with RESET_PC=64'h1000 -> fetch_req pulse with fetch_addr=64'h1000; return 32'h00000013 -> inst=32'h00000013, inst_comp=0, inst_pc=64'h1000 one cycle later.
2. Word 32'h45014501 at 64'h1000 -> two heads: inst=32'h4501 pc 64'h1000, then inst=32'h4501 pc 64'h1002, both inst_comp=1.
3. Straddle: word at 64'h1000 = 32'h00134501, word at 64'h1004 = 32'h4501_0000 -> heads: pc 64'h1000 RVC 32'h4501; pc 64'h1002 32'h00000013; pc 64'h1006 RVC 32'h4501.
4. Hold inst_ready=0 with DEPTH=4 -> after 2 full words no further fetch_req; one pop leaves only 1 free entry, so still no request; a second pop frees 2 and fetch_req fires the next cycle.
5. Redirect to 64'h2002 while in WAIT -> queue empty next cycle; the late fetch_valid is dropped; next fetch_addr=64'h2000; only the upper half is used, so inst_pc=64'h2002.
6. rst_n asserted low mid-WAIT with 3 queue entries -> inst_valid=0 and fetch_addr=64'h1000 immediately; fetch resumes after rst_n deasserts.
